serdes_word_tx: RTL

Parallel-to-serial word transmitter for the eddr3 SERDES bring-up path: accepts DATA_WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per hsclk cycle, with a word-boundary strobe. Its serial output drives the ISERDESE2 8:1 capture path, and it can be held in training mode to emit a fixed pattern for bitslip word alignment. When no data is available it inserts an idle word and counts the gap.

---
 rtl/serdes_word_tx.sv | 81 ++++++++
 1 files changed

// File: rtl/serdes_word_tx.sv
// serdes_word_tx: parallel-to-serial word transmitter, MSB first, one bit per
// hsclk. Continuous word framing: every DATA_WIDTH cycles a new word is loaded
// from training pattern, hold register, the input (bypass) or the idle word.
module serdes_word_tx #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(8'hfa),
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = DATA_WIDTH'(8'h00)
) (
  input  logic                  hsclk,
  input  logic                  reset_n,
  input  logic                  train,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  dout,
  output logic                  frame,
  output logic [15:0]           word_cnt,
  output logic [15:0]           underrun_cnt
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  hold_full;
  logic                  load;
  logic                  xfer;

  // A word may only be accepted when the single hold slot is free; this keeps
  // at most one word waiting behind the one on the wire.
  assign s_ready = !hold_full;
  assign xfer    = s_valid && s_ready;
  assign load    = (bit_cnt == '0);
  assign dout    = shift_reg[DATA_WIDTH-1];

  // Bit counter, shifter, word-source selection, hold slot and counters.
  always_ff @(posedge hsclk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt      <= '0;
      shift_reg    <= '0;
      hold_reg     <= '0;
      hold_full    <= 1'b0;
      frame        <= 1'b0;
      word_cnt     <= '0;
      underrun_cnt <= '0;
    end else begin
      bit_cnt <= (bit_cnt == CNT_W'(DATA_WIDTH-1)) ? '0 : bit_cnt + CNT_W'(1);
      frame   <= load;
      if (load) begin
        if (train) begin
          // Training pre-empts data but never drops it: a word arriving now
          // is parked in the hold slot and goes out in the next slot.
          shift_reg <= TRAIN_PATTERN;
          if (xfer) begin
            hold_reg  <= s_data;
            hold_full <= 1'b1;
          end
        end else if (hold_full) begin
          shift_reg <= hold_reg;
          hold_full <= 1'b0;
          word_cnt  <= word_cnt + 16'd1;
        end else if (xfer) begin
          shift_reg <= s_data;
          word_cnt  <= word_cnt + 16'd1;
        end else begin
          shift_reg <= IDLE_WORD;
          if (underrun_cnt != 16'hffff)
            underrun_cnt <= underrun_cnt + 16'd1;
        end
      end else begin
        shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
        if (xfer) begin
          hold_reg  <= s_data;
          hold_full <= 1'b1;
        end
      end
    end
  end

endmodule
